// File: rtl/mem_access_unit_if.sv
// Shared memory port between the MEM-stage access unit (master) and the memory (slave).
// Wait states are inserted by holding mem_ack low while mem_req is high.
interface mem_access_unit_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 16
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage access controller: arbitrates one memory port between instruction fetch and
// LDR/STR data accesses, with req/ack wait states, a watchdog abort and a registered write-back.
module mem_access_unit #(
   parameter int         DATA_W   = 32,
   parameter int         ADDR_W   = 16,
   parameter int         PC_W     = 8,
   parameter logic [3:0] OP_LDR   = 4'b1101,
   parameter logic [3:0] OP_STR   = 4'b1110,
   parameter int         WAIT_MAX = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [3:0]        op_code,
   input  logic [DATA_W-1:0] src1,
   input  logic [DATA_W-1:0] src2,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              fetch_req,
   input  logic [PC_W-1:0]   pc,
   output logic              fetch_done,
   output logic [DATA_W-1:0] instr,
   output logic              wb_valid,
   output logic [DATA_W-1:0] wb_data,
   output logic              err,
   mem_access_unit_if.master mem
);

   typedef enum logic [1:0] {IDLE, DATA, FETCH} state_t;

   state_t     state, state_nxt;
   logic       is_load;
   logic [7:0] wait_cnt;
   logic       accept, is_mem_op, acked, timed_out;
   logic       unused_src1_hi;

   assign unused_src1_hi = ^src1[DATA_W-1:ADDR_W];

   assign op_ready  = (state == IDLE);
   assign accept    = op_valid && op_ready;
   assign is_mem_op = (op_code == OP_LDR) || (op_code == OP_STR);
   // A spurious ack with no request outstanding never completes anything.
   assign acked     = mem.mem_req && mem.mem_ack;
   assign timed_out = mem.mem_req && !mem.mem_ack && (wait_cnt == 8'(WAIT_MAX - 1));

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: defaults first so every path assigns state_nxt and no latch is inferred.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (accept && is_mem_op)   state_nxt = DATA;
            else if (!accept && fetch_req) state_nxt = FETCH;
         end
         DATA, FETCH: begin
            if (acked || timed_out) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The cycle after entering DATA/FETCH raises mem_req; the request is then held stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem.mem_req   <= 1'b0;
         mem.mem_we    <= 1'b0;
         mem.mem_addr  <= '0;
         mem.mem_wdata <= '0;
         wb_valid      <= 1'b0;
         wb_data       <= '0;
         fetch_done    <= 1'b0;
         instr         <= '0;
         err           <= 1'b0;
         is_load       <= 1'b0;
         wait_cnt      <= '0;
      end else begin
         wb_valid   <= 1'b0;
         fetch_done <= 1'b0;
         err        <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept && is_mem_op) begin
                  mem.mem_addr  <= src1[ADDR_W-1:0];
                  mem.mem_wdata <= src2;
                  mem.mem_we    <= (op_code == OP_STR);
                  is_load       <= (op_code == OP_LDR);
                  wait_cnt      <= '0;
               end else if (accept) begin
                  wb_data  <= alu_result;
                  wb_valid <= 1'b1;
               end else if (fetch_req) begin
                  mem.mem_addr <= ADDR_W'(pc);
                  mem.mem_we   <= 1'b0;
                  is_load      <= 1'b0;
                  wait_cnt     <= '0;
               end
            end
            DATA, FETCH: begin
               if (!mem.mem_req) begin
                  mem.mem_req <= 1'b1;
               end else if (acked || timed_out) begin
                  mem.mem_req <= 1'b0;
                  mem.mem_we  <= 1'b0;
                  err         <= timed_out;
                  if (state == FETCH) begin
                     instr      <= acked ? mem.mem_rdata : '0;
                     fetch_done <= 1'b1;
                  end else if (is_load) begin
                     wb_data  <= acked ? mem.mem_rdata : '0;
                     wb_valid <= 1'b1;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
